// File: rtl/fft8_frame_loader.sv
// Packs single-precision samples into 256-bit FFT input frames using two ping-pong slots.
// Short frames closed by s_last are padded with PAD_WORD and flagged on m_short.
module fft8_frame_loader #(
    parameter int                  SAMPLE_W  = 32,
    parameter int                  N_SAMPLES = 8,
    parameter logic [SAMPLE_W-1:0] PAD_WORD  = '0
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          s_valid,
    output logic                          s_ready,
    input  logic [SAMPLE_W-1:0]           s_data,
    input  logic                          s_last,
    output logic                          m_valid,
    input  logic                          m_ready,
    output logic [SAMPLE_W*N_SAMPLES-1:0] m_data,
    output logic                          m_short,
    output logic [15:0]                   frame_cnt
);
    localparam int FRAME_W = SAMPLE_W * N_SAMPLES;
    localparam int IDX_W   = (N_SAMPLES > 1) ? $clog2(N_SAMPLES) : 1;

    typedef enum logic [1:0] {EMPTY, FILLING, FULL} slot_st_t;

    slot_st_t           st_q    [2];
    slot_st_t           st_d    [2];
    logic [FRAME_W-1:0] data_q  [2];
    logic [FRAME_W-1:0] data_d  [2];
    logic [1:0]         short_q, short_d;
    logic               wr_q, wr_d, rd_q, rd_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic               s_ready_q, s_ready_d;
    logic [15:0]        cnt_q, cnt_d;
    logic               acc, pop, close;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 2; i++) begin
                st_q[i]   <= EMPTY;
                data_q[i] <= '0;
            end
            short_q   <= '0;
            wr_q      <= 1'b0;
            rd_q      <= 1'b0;
            idx_q     <= '0;
            s_ready_q <= 1'b0;
            cnt_q     <= '0;
        end else begin
            for (int i = 0; i < 2; i++) begin
                st_q[i]   <= st_d[i];
                data_q[i] <= data_d[i];
            end
            short_q   <= short_d;
            wr_q      <= wr_d;
            rd_q      <= rd_d;
            idx_q     <= idx_d;
            s_ready_q <= s_ready_d;
            cnt_q     <= cnt_d;
        end
    end

    always_comb begin
        for (int i = 0; i < 2; i++) begin
            st_d[i]   = st_q[i];
            data_d[i] = data_q[i];
        end
        short_d = short_q;
        wr_d    = wr_q;
        rd_d    = rd_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;

        acc   = s_valid && s_ready_q;
        pop   = (st_q[rd_q] == FULL) && m_ready;
        close = s_last || (idx_q == IDX_W'(N_SAMPLES - 1));

        // The popped slot is FULL and the write slot never is, so these never collide.
        if (pop) begin
            st_d[rd_q] = EMPTY;
            rd_d       = ~rd_q;
            cnt_d      = cnt_q + 16'd1;
        end

        if (acc) begin
            for (int j = 0; j < N_SAMPLES; j++) begin
                if (j == int'(idx_q))
                    data_d[wr_q][FRAME_W-1-SAMPLE_W*j -: SAMPLE_W] = s_data;
                else if (close && j > int'(idx_q))
                    data_d[wr_q][FRAME_W-1-SAMPLE_W*j -: SAMPLE_W] = PAD_WORD;
            end
            if (close) begin
                st_d[wr_q]    = FULL;
                short_d[wr_q] = (idx_q != IDX_W'(N_SAMPLES - 1));
                wr_d          = ~wr_q;
                idx_d         = '0;
            end else begin
                st_d[wr_q] = FILLING;
                idx_d      = idx_q + 1'b1;
            end
        end

        s_ready_d = (st_d[wr_d] != FULL);
    end

    assign s_ready   = s_ready_q;
    assign m_valid   = (st_q[rd_q] == FULL);
    assign m_data    = data_q[rd_q];
    assign m_short   = m_valid && short_q[rd_q];
    assign frame_cnt = cnt_q;

endmodule
